// File: rtl/board_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : board_pkg
//  Purpose  : Shared types, constants and the line/position-to-cell mapping
//             for the 4x4 sliding-tile board mover.
//  Revision : 1.0 - initial release
// ============================================================================
package board_pkg;

    localparam int CELL_W    = 4;
    localparam int BOARD_W   = 64;
    localparam int NUM_CELLS = 16;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Position 0 is always the wall the tiles slide towards; the result is
    // the flat cell index 4*row+col.
    function automatic logic [3:0] cell_index(input logic [1:0] dir,
                                              input logic [1:0] line,
                                              input logic [1:0] pos);
        logic [1:0] row;
        logic [1:0] col;
        row = line;
        col = pos;
        case (dir)
            DIR_LEFT:  begin row = line;         col = pos;          end
            DIR_RIGHT: begin row = line;         col = 2'd3 - pos;   end
            DIR_UP:    begin row = pos;          col = line;         end
            DIR_DOWN:  begin row = 2'd3 - pos;   col = line;         end
        endcase
        return {row, col};
    endfunction

endpackage
`default_nettype wire

// File: rtl/board_shift_if.sv
`default_nettype none
// ============================================================================
//  Module   : board_shift_if
//  Purpose  : Command/result bundle of the board mover.
//  Revision : 1.0 - initial release
// ============================================================================
interface board_shift_if;
    import board_pkg::*;

    logic                  start;
    logic [1:0]            dir;
    logic [BOARD_W-1:0]    board_in;
    logic [BOARD_W-1:0]    board_out;
    logic                  busy;
    logic                  done;
    logic                  moved;
    logic [3:0]            merge_cnt;

    modport master (
        output start, dir, board_in,
        input  board_out, busy, done, moved, merge_cnt
    );

    modport slave (
        input  start, dir, board_in,
        output board_out, busy, done, moved, merge_cnt
    );

endinterface
`default_nettype wire

// File: rtl/move_cell.sv
`default_nettype none
// ============================================================================
//  Module   : move_cell
//  Purpose  : Combinational evaluation of one (from, to) cell pair: slide
//             into an empty cell, merge equal values, or leave unchanged.
//  Revision : 1.0 - initial release
// ============================================================================
module move_cell
    import board_pkg::*;
(
    input  wire logic [CELL_W-1:0] i_from,
    input  wire logic [CELL_W-1:0] i_to,
    input  wire logic              i_to_is_marked,
    output logic      [CELL_W-1:0] o_from,
    output logic      [CELL_W-1:0] o_to,
    output logic                   o_slid,
    output logic                   o_merged
);

    // A marked target (already merged this move, or saturated at 15) blocks
    // both sliding and merging.
    always_comb begin
        o_from   = i_from;
        o_to     = i_to;
        o_slid   = 1'b0;
        o_merged = 1'b0;
        if (i_from != '0 && !i_to_is_marked) begin
            if (i_to == '0) begin
                o_to   = i_from;
                o_from = '0;
                o_slid = 1'b1;
            end else if (i_to == i_from) begin
                o_to     = i_to + 1'b1;
                o_from   = '0;
                o_merged = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/board_shift.sv
`default_nettype none
// ============================================================================
//  Module   : board_shift
//  Purpose  : Sequential 4x4 tile-board mover. One cell pair is evaluated per
//             cycle, walking each line from the wall outwards, so a move takes
//             12..24 STEP cycles followed by a single DONE cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module board_shift
    import board_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    board_shift_if.slave    bus
);

    state_t                 r_state;
    logic [BOARD_W-1:0]     r_board;
    logic [1:0]             r_dir;
    logic [NUM_CELLS-1:0]   r_marks;
    logic [1:0]             r_line;
    logic [1:0]             r_src;
    logic [1:0]             r_pos;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_moved;
    logic [3:0]             r_merge_cnt;

    logic [3:0]             w_from_idx;
    logic [3:0]             w_to_idx;
    logic [CELL_W-1:0]      w_from_val;
    logic [CELL_W-1:0]      w_to_val;
    logic                   w_to_marked;
    logic [CELL_W-1:0]      w_new_from;
    logic [CELL_W-1:0]      w_new_to;
    logic                   w_slid;
    logic                   w_merged;

    // Address mux: pick the current pair and its merge-blocking status.
    always_comb begin
        w_from_idx  = cell_index(r_dir, r_line, r_pos);
        w_to_idx    = cell_index(r_dir, r_line, r_pos - 2'd1);
        w_from_val  = r_board[{w_from_idx, 2'b00} +: CELL_W];
        w_to_val    = r_board[{w_to_idx, 2'b00} +: CELL_W];
        w_to_marked = r_marks[w_to_idx] | (w_to_val == {CELL_W{1'b1}});
    end

    move_cell u_move_cell (
        .i_from         (w_from_val),
        .i_to           (w_to_val),
        .i_to_is_marked (w_to_marked),
        .o_from         (w_new_from),
        .o_to           (w_new_to),
        .o_slid         (w_slid),
        .o_merged       (w_merged)
    );

    // Control FSM, pair write-back, marks and result flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_board     <= '0;
            r_dir       <= DIR_UP;
            r_marks     <= '0;
            r_line      <= 2'd0;
            r_src       <= 2'd1;
            r_pos       <= 2'd1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_moved     <= 1'b0;
            r_merge_cnt <= 4'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_board     <= bus.board_in;
                        r_dir       <= bus.dir;
                        r_marks     <= '0;
                        r_moved     <= 1'b0;
                        r_merge_cnt <= 4'd0;
                        r_line      <= 2'd0;
                        r_src       <= 2'd1;
                        r_pos       <= 2'd1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    r_board[{w_from_idx, 2'b00} +: CELL_W] <= w_new_from;
                    r_board[{w_to_idx, 2'b00} +: CELL_W]   <= w_new_to;
                    if (w_merged) begin
                        r_marks[w_to_idx] <= 1'b1;
                        r_merge_cnt       <= r_merge_cnt + 4'd1;
                    end
                    if (w_slid || w_merged) begin
                        r_moved <= 1'b1;
                    end
                    // A slide keeps chasing the tile towards the wall; every
                    // other outcome moves on to the next source tile.
                    if (w_slid && r_pos > 2'd1) begin
                        r_pos <= r_pos - 2'd1;
                    end else if (r_src < 2'd3) begin
                        r_src <= r_src + 2'd1;
                        r_pos <= r_src + 2'd1;
                    end else if (r_line < 2'd3) begin
                        r_line <= r_line + 2'd1;
                        r_src  <= 2'd1;
                        r_pos  <= 2'd1;
                    end else begin
                        r_line  <= 2'd0;
                        r_src   <= 2'd1;
                        r_pos   <= 2'd1;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.board_out = r_board;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.moved     = r_moved;
    assign bus.merge_cnt = r_merge_cnt;

endmodule
`default_nettype wire

// File: tb/tb_board_shift.sv
`default_nettype none
// ============================================================================
//  Module   : tb_board_shift
//  Purpose  : Directed self-checking bench for board_shift.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_board_shift;
    import board_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   cyc;
    int   done_seen;

    board_shift_if bus ();

    board_shift dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one move; start is held for 'hold' cycles (extra cycles fall in
    // STEP and must be ignored). Returns cycles from start to done (100 on
    // timeout), sampled on the falling edge.
    task automatic do_move(input logic [63:0] b, input logic [1:0] d,
                           input int hold, output int n);
        @(negedge clk);
        bus.board_in = b;
        bus.dir      = d;
        bus.start    = 1'b1;
        n = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n++;
            bus.board_in = 64'hFEDC_BA98_7654_3210;
            bus.dir      = ~d;
        end
        bus.start = 1'b0;
        while (!bus.done && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_result(input string tag, input logic [63:0] b_exp,
                                input logic mv_exp, input logic [3:0] cnt_exp);
        check({tag, "_done_seen"}, 64'(cyc < 100), 64'd1);
        check({tag, "_busy_in_done"}, 64'(bus.busy), 64'd1);
        check({tag, "_board"}, bus.board_out, b_exp);
        check({tag, "_moved"}, 64'(bus.moved), 64'(mv_exp));
        check({tag, "_merge_cnt"}, 64'(bus.merge_cnt), 64'(cnt_exp));
        bus.board_in = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
        check({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
        @(negedge clk);
        check({tag, "_board_hold"}, bus.board_out, b_exp);
        check({tag, "_cnt_hold"}, 64'(bus.merge_cnt), 64'(cnt_exp));
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dir      = DIR_UP;
        bus.board_in = 64'h1111_1111_1111_1111;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        rst = 1'b0;

        check("rst_board", bus.board_out, 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_moved", 64'(bus.moved), 64'd0);
        check("rst_cnt", 64'(bus.merge_cnt), 64'd0);

        // Row0 [1,1,2,2] left -> [2,3,0,0]
        do_move(64'h2211, DIR_LEFT, 1, cyc);
        check_result("left_1122", 64'h0032, 1'b1, 4'd2);

        // Row0 [1,1,1,1] left -> [2,2,0,0]; start held into STEP
        do_move(64'h1111, DIR_LEFT, 3, cyc);
        check_result("left_1111", 64'h0022, 1'b1, 4'd2);

        // Row0 [0,1,1,2] right -> [0,0,2,2]
        do_move(64'h2110, DIR_RIGHT, 1, cyc);
        check_result("right_0112", 64'h2200, 1'b1, 4'd1);

        // Column0 [2,0,0,2] up -> [3,0,0,0]
        do_move(64'h0002_0000_0000_0002, DIR_UP, 1, cyc);
        check_result("up_col0", 64'h0003, 1'b1, 4'd1);

        // Column0 [2,0,0,2] down -> [0,0,0,3]
        do_move(64'h0002_0000_0000_0002, DIR_DOWN, 1, cyc);
        check_result("down_col0", 64'h0003_0000_0000_0000, 1'b1, 4'd1);

        // Row0 [15,15,0,0] left -> unchanged
        do_move(64'h00FF, DIR_LEFT, 1, cyc);
        check_result("left_ff", 64'h00FF, 1'b0, 4'd0);

        // Checkerboard: no move, exactly 12 STEP + DONE
        do_move(64'h1212_2121_1212_2121, DIR_DOWN, 1, cyc);
        check("chk_latency", 64'(cyc), 64'd13);
        check_result("checker", 64'h1212_2121_1212_2121, 1'b0, 4'd0);

        // Reset five cycles into a move aborts it
        @(negedge clk);
        bus.board_in = 64'h2211;
        bus.dir      = DIR_LEFT;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("abort_busy_mid", 64'(bus.busy), 64'd1);
        for (int i = 0; i < 4; i++) @(negedge clk);
        rst = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b0;
        check("abort_board", bus.board_out, 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_moved", 64'(bus.moved), 64'd0);
        check("abort_cnt", 64'(bus.merge_cnt), 64'd0);
        done_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_seen++;
        end
        check("abort_no_done", 64'(done_seen), 64'd0);

        // Normal move after the abort
        do_move(64'h2211, DIR_LEFT, 1, cyc);
        check_result("post_abort", 64'h0032, 1'b1, 4'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/board_shift.md
BOARD_SHIFT -- requirements
Module: board_shift

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 The block SHALL have these ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin one move; sampled only in IDLE
- dir  in  2  0=up, 1=down, 2=left, 3=right
- board_in  in  64  16 cells × 4-bit exponent, 0=empty; cell(r,c) at bits [4*(4r+c)+3 : 4*(4r+c)]
- board_out  out  64  working/result board, same packing
- busy  out  1  move in progress
- done  out  1  one-cycle pulse, result valid
- moved  out  1  result differs from the board latched at start
- merge_cnt  out  4  number of merges in this move (0..8)

Function
REQ-003 FSM states SHALL be IDLE, STEP, DONE; transitions: IDLE→STEP on start, STEP→DONE after the last line completes, DONE→IDLE unconditionally.
REQ-004 On start in IDLE the block SHALL latch board_in into board_out, latch dir, clear 16 merge marks, clear moved and merge_cnt, and set line=0, src=1, pos=1.
REQ-005 start SHALL be ignored in STEP and DONE; dir and board_in SHALL be don't-care outside the start cycle.
REQ-006 Line/position mapping (position 0 = wall side): left line=r, c=p; right line=r, c=3-p; up line=c, r=p; down line=c, r=3-p.
REQ-007 Each STEP cycle SHALL evaluate exactly one pair: from=cell(line,pos), to=cell(line,pos-1), via one combinational cell mover, and write both results back the same cycle.
REQ-008 Slide (from≠0, to=0, to unmarked): to←from, from←0; if pos>1 then pos←pos-1, else advance.
REQ-009 Merge (from≠0, from=to, to unmarked, to<15): to←to+1, from←0, set mark(to), merge_cnt+1, advance.
REQ-010 Every other case (from=0, to marked, from≠to, or to=15) SHALL leave both cells unchanged and advance.
REQ-011 Advance: if src<3 then src←src+1, pos←src+1; else if line<3 then line+1, src=1, pos=1; else the next state is DONE.
REQ-012 A cell of value 15 SHALL never merge; the mover's to_is_marked input is driven high whenever mark(to) or to=15.
REQ-013 moved SHALL be set on any slide or merge; it is sticky until the next start.
REQ-014 STEP duration SHALL be 12..24 cycles (3..6 per line); done SHALL pulse in the DONE cycle; busy SHALL be high throughout STEP and DONE.
REQ-015 board_out, moved and merge_cnt SHALL hold their values from done until the next accepted start.

Reset
REQ-016 rst SHALL force IDLE and set board_out=0, busy=0, done=0, moved=0, merge_cnt=0, and all marks=0; line/src/pos return to their start values.
REQ-017 rst asserted mid-move SHALL abort the move with no done pulse; rst has priority over start in the same cycle.

Structure
REQ-018 The shared package board_pkg SHALL hold the direction encodings, CELL_W=4, the board width of 64, the FSM state encodings, and the cell index/mapping function.
REQ-019 The block SHALL instantiate exactly one move_cell for the pair evaluation; address mux, demux, marks and FSM are local to board_shift.

Verification
REQ-020 The bench SHALL cover:
- Row0 [1,1,2,2], dir=left → row0 [2,3,0,0]; moved=1; merge_cnt=2.
- Row0 [1,1,1,1], dir=left → row0 [2,2,0,0]; merge_cnt=2; the marked cell does not merge again.
- Row0 [0,1,1,2], dir=right → row0 [0,0,2,2]; merge_cnt=1.
- Column0 [2,0,0,2] (rows 0..3), dir=up → column0 [3,0,0,0]. Row0 [15,15,0,0], dir=left → unchanged; moved=0; merge_cnt=0.
- Checkerboard of 1/2, any dir → unchanged; moved=0; done exactly 13 cycles after start (12 STEP + DONE).
- rst pulsed 5 cycles after start → IDLE, all outputs 0, no done; a following start runs normally.
